set_job_arbiter: RTL and testbench

- Round-robin scheduler that shares one SET lattice-count engine among NREQ requesters.
- Accepts jobs (central, radius, mode), issues each to the engine with a one-cycle en pulse while the engine is not busy, and captures candidate on valid.
- Returns each result tagged with the requester id.
- Sits between client blocks and the single SET instance; the engine's ports connect 1:1 to the eng_* ports.

---
 rtl/set_job_arbiter.sv | 172 +++++++++++++++++
 tb/tb_set_job_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_job_arbiter.sv
// rtl/set_job_arbiter.sv - round-robin job arbiter sharing one SET lattice-count engine
// Optional watchdog on the engine wait is enabled by defining SET_ARB_TIMEOUT_EN.
module set_job_arbiter #(
    parameter int NREQ        = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*24-1:0]   req_central,
    input  logic [NREQ*12-1:0]   req_radius,
    input  logic [NREQ*2-1:0]    req_mode,
    output logic                 eng_en,
    output logic [23:0]          eng_central,
    output logic [11:0]          eng_radius,
    output logic [1:0]           eng_mode,
    input  logic                 eng_busy,
    input  logic                 eng_valid,
    input  logic [7:0]           eng_candidate,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_candidate,
    output logic                 rsp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [23:0]      central_q, central_d;
    logic [11:0]      radius_q, radius_d;
    logic [1:0]       mode_q, mode_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [7:0]       cand_q, cand_d;

    logic [2*NREQ-1:0] req_win;
    logic [ID_W-1:0]   grant_off, grant_idx, rr_next;
    logic [ID_W:0]     grant_sum, next_sum;
    logic              grant_found, accept;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        req_win     = {req_valid, req_valid} >> rr_ptr_q;
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_win[k]) begin
                grant_found = 1'b1;
                grant_off   = ID_W'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        if (grant_sum >= (ID_W+1)'(NREQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(NREQ);
        end
        grant_idx = grant_sum[ID_W-1:0];
        next_sum  = {1'b0, grant_idx} + (ID_W+1)'(1);
        if (next_sum >= (ID_W+1)'(NREQ)) begin
            next_sum = '0;
        end
        rr_next = next_sum[ID_W-1:0];
    end

    assign accept    = rst && (state_q == S_IDLE) && !eng_busy && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

`ifdef SET_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        id_d      = id_q;
        cand_d    = cand_q;
`ifdef SET_ARB_TIMEOUT_EN
        timer_d   = timer_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    central_d = req_central[grant_idx*24 +: 24];
                    radius_d  = req_radius[grant_idx*12 +: 12];
                    mode_d    = req_mode[grant_idx*2 +: 2];
                    id_d      = grant_idx;
                    rr_ptr_d  = rr_next;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SET_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            S_WAIT: begin
                if (eng_valid) begin
                    cand_d  = eng_candidate;
                    state_d = S_RESP;
`ifdef SET_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    cand_d  = 8'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
`endif
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            id_q      <= '0;
            cand_q    <= '0;
`ifdef SET_ARB_TIMEOUT_EN
            timer_q   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
            id_q      <= id_d;
            cand_q    <= cand_d;
`ifdef SET_ARB_TIMEOUT_EN
            timer_q   <= timer_d;
            err_q     <= err_d;
`endif
        end
    end

    assign eng_en        = (state_q == S_ISSUE);
    assign rsp_valid     = (state_q == S_RESP);
    assign eng_central   = central_q;
    assign eng_radius    = radius_q;
    assign eng_mode      = mode_q;
    assign rsp_id        = id_q;
    assign rsp_candidate = cand_q;
`ifdef SET_ARB_TIMEOUT_EN
    assign rsp_err       = err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_set_job_arbiter.sv
// tb/tb_set_job_arbiter.sv - self-checking bench for set_job_arbiter
module tb_set_job_arbiter;
    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [95:0]     req_central;
    logic [47:0]     req_radius;
    logic [7:0]      req_mode;
    logic            eng_en;
    logic [23:0]     eng_central;
    logic [11:0]     eng_radius;
    logic [1:0]      eng_mode;
    logic            eng_busy;
    logic            eng_valid;
    logic [7:0]      eng_candidate;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_candidate;
    logic            rsp_err;

    always #5 clk = ~clk;

    set_job_arbiter #(.NREQ(4), .ID_W(2), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
        .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_candidate(eng_candidate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_candidate(rsp_candidate), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] cand;
        logic       err;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         exp_id;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Engine model knobs and captured job
    int          eng_lat     = 3;
    bit          drop_result = 1'b0;
    bit          force_busy  = 1'b0;
    bit          busy_int    = 1'b0;
    int          cnt         = 0;
    int          en_count    = 0;
    logic [23:0] cap_c;
    logic [11:0] cap_r;
    logic [1:0]  cap_m;

    assign eng_busy = busy_int | force_busy;

    function automatic logic [7:0] cand_f(logic [23:0] c, logic [11:0] r, logic [1:0] m);
        int s;
        if (c == 24'h334455) return 8'd37;
        s = int'(c[7:0]) + int'(r[7:0]) + int'(m);
        return 8'(s % 65);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        eng_valid     = 1'b0;
        eng_candidate = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                cnt       = 0;
                busy_int  = 1'b0;
                eng_valid = 1'b0;
            end else begin
                eng_valid = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy_int = 1'b0;
                        if (!drop_result) begin
                            eng_valid     = 1'b1;
                            eng_candidate = cand_f(cap_c, cap_r, cap_m);
                        end
                    end
                end
                if (eng_en) begin
                    en_count++;
                    cap_c    = eng_central;
                    cap_r    = eng_radius;
                    cap_m    = eng_mode;
                    cnt      = eng_lat;
                    busy_int = 1'b1;
                end
            end
        end
    end

    // Grant/response scoreboard: expected result pushed at grant, popped at response.
    int   exp_ptr = 0;
    int   mon_g;
    int   mon_idx;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                exp_ptr = 0;
            end else begin
                if (req_ready != 4'd0) begin
                    mon_g = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        mon_idx = (exp_ptr + k) % NREQ;
                        if (mon_g < 0 && req_valid[mon_idx]) mon_g = mon_idx;
                    end
                    if (mon_g < 0) begin
                        check("grant_without_valid", 32'(req_ready), 32'd0);
                    end else begin
                        check("grant_rr", 32'(req_ready), 32'd1 << mon_g);
                        mon_e.id = 2'(mon_g);
                        if (drop_result) begin
`ifdef SET_ARB_TIMEOUT_EN
                            mon_e.cand = 8'd0;
                            mon_e.err  = 1'b1;
                            sb.push_back(mon_e);
`endif
                        end else begin
                            mon_e.cand = cand_f(req_central[mon_g*24 +: 24],
                                                req_radius[mon_g*12 +: 12],
                                                req_mode[mon_g*2 +: 2]);
                            mon_e.err  = 1'b0;
                            sb.push_back(mon_e);
                        end
                        exp_ptr = (mon_g + 1) % NREQ;
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                        check("rsp_candidate", 32'(rsp_candidate), 32'(mon_e.cand));
                        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    end
                end
            end
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready != 4'd0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the response handshake.
    task automatic run_job(logic [3:0] mask, int exp_id);
        bit ok;
        req_valid = mask;
        wait_grant(ok);
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
        else check("grant_id", 32'(req_ready), 32'd1 << exp_id);
        wait_rsp(ok);
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
        tick();
    endtask

    vec_t vecs[16];
    int   en0;
    int   seen;
    bit   ok;
    logic [7:0] hold_cand;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_central[i*24 +: 24] = 24'h0a1b00 + 24'(i * 17);
            req_radius[i*12 +: 12]  = 12'h100 + 12'(i * 5);
            req_mode[i*2 +: 2]      = 2'(i);
        end

        // Reset held with all requesters pending
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rst_eng_en", 32'(eng_en), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_err", 32'(rsp_err), 32'd0);
            check("rst_eng_central", 32'(eng_central), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("rst_rsp_candidate", 32'(rsp_candidate), 32'd0);
        end
        tick();
        rst = 1'b1;
        run_job(4'hf, 0);

        // Single job from requester 2, long engine latency
        req_central[2*24 +: 24] = 24'h334455;
        req_radius[2*12 +: 12]  = 12'h432;
        req_mode[2*2 +: 2]      = 2'b01;
        eng_lat = 20;
        en0 = en_count;
        run_job(4'b0100, 2);
        check("single_en_pulses", 32'(en_count - en0), 32'd1);
        check("single_central", 32'(cap_c), 32'h334455);
        check("single_radius", 32'(cap_r), 32'h432);
        check("single_mode", 32'(cap_m), 32'd1);
        eng_lat = 3;

        // Round-robin order and skipping of non-requesting slots
        vecs[0]  = '{4'b1000, 3};
        for (int i = 1; i <= 8; i++) vecs[i] = '{4'b1111, (i - 1) % 4};
        vecs[9]  = '{4'b1010, 1};
        vecs[10] = '{4'b1010, 3};
        vecs[11] = '{4'b0001, 0};
        vecs[12] = '{4'b0100, 2};
        vecs[13] = '{4'b0011, 0};
        vecs[14] = '{4'b0011, 1};
        vecs[15] = '{4'b0110, 2};
        for (int i = 0; i < 16; i++) run_job(vecs[i].mask, vecs[i].exp_id);

        // Backpressure: response held, no new issue while RESP
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        wait_grant(ok);
        check("bp_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'hf;
        wait_rsp(ok);
        check("bp_rsp_seen", 32'(ok), 32'd1);
        en0 = en_count;
        hold_cand = cand_f(req_central[3*24 +: 24], req_radius[3*12 +: 12], req_mode[3*2 +: 2]);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'd3);
            check("bp_cand", 32'(rsp_candidate), 32'(hold_cand));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        check("bp_no_issue", 32'(en_count - en0), 32'd0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        run_job(4'hf, 0);

        // Busy gate: grant only once eng_busy falls
        force_busy = 1'b1;
        req_valid  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_gate", 32'(req_ready), 32'd0);
            tick();
        end
        force_busy = 1'b0;
        @(negedge clk);
        check("busy_release_grant", 32'(req_ready), 32'b0010);
        wait_rsp(ok);
        check("busy_rsp_seen", 32'(ok), 32'd1);
        tick();

        // Engine never answers
        drop_result = 1'b1;
        eng_lat     = 40;
        req_valid   = 4'b0001;
        wait_grant(ok);
        check("drop_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
`ifdef SET_ARB_TIMEOUT_EN
        wait_rsp(ok);
        check("timeout_rsp_seen", 32'(ok), 32'd1);
        tick();
        drop_result = 1'b0;
        eng_lat     = 3;
        run_job(4'hf, 1);
`else
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_timeout_rsp", 32'(seen), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("midjob_rst_valid", 32'(rsp_valid), 32'd0);
        check("midjob_rst_en", 32'(eng_en), 32'd0);
        tick();
        rst         = 1'b1;
        drop_result = 1'b0;
        eng_lat     = 3;
        run_job(4'hf, 0);
`endif
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
